// File: rtl/i2s_pkg.sv
// Shared I2S types and constants for the receive and transmit audio paths.
// Definitions only: no logic, no latency, no flow control.
package i2s_pkg;

    localparam int I2S_DATA_BIT = 16;

    typedef enum logic {
        RX_UNLOCKED = 1'b0,
        RX_LOCKED   = 1'b1
    } rx_state_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_t;

    // Rising edges without a word-select change before the receiver gives up lock.
    function automatic int stall_edges(input int data_bit);
        return 2 * data_bit + 2;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin, with edge pulses from the synchronized level.
// level lags the pin by SYNC_STAGES cycles; rise/fall are one-cycle pulses, no backpressure.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: synchronizes async pins, deserializes MSB-first L/R words, strobes complete pairs.
// Latency SYNC_STAGES clk_12_288 cycles from the LSB's sclk rise; no backpressure, valid/frame_err are one-cycle strobes.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_BIT    = I2S_DATA_BIT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_12_288,
    input  logic                reset_n,
    input  logic                sclk_in,
    input  logic                lrclk_in,
    input  logic                sd_in,
    output logic [DATA_BIT-1:0] audio_l,
    output logic [DATA_BIT-1:0] audio_r,
    output logic                valid,
    output logic                frame_err
);

    localparam int CNT_W = $clog2(DATA_BIT + 2);
    localparam int RUN_W = $clog2(stall_edges(DATA_BIT) + 1);
    localparam logic [CNT_W-1:0] BIT_SAT  = CNT_W'(DATA_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(DATA_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BIT - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(stall_edges(DATA_BIT) - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ws, ws_rise, ws_fall;
    logic sd, sd_rise, sd_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk_12_288), .rst_n(reset_n), .pin(sclk_in),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
        .clk(clk_12_288), .rst_n(reset_n), .pin(lrclk_in),
        .level(ws), .rise(ws_rise), .fall(ws_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(clk_12_288), .rst_n(reset_n), .pin(sd_in),
        .level(sd), .rise(sd_rise), .fall(sd_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_level, sclk_fall, ws_rise, ws_fall, sd_rise, sd_fall};

    rx_state_t           state;
    logic                ws_prev;
    logic [CNT_W-1:0]    bit_cnt;
    logic [RUN_W-1:0]    run_cnt;
    logic [DATA_BIT-1:0] shreg;
    logic [DATA_BIT-1:0] hold_l;
    logic                l_ok;
    logic [DATA_BIT-1:0] word;
    logic                slot_good;

    // Bits beyond DATA_BIT are truncated: the shifter freezes once full.
    always_comb begin
        word = shreg;
        if (bit_cnt < BIT_FULL) begin
            word = {shreg[DATA_BIT-2:0], sd};
        end
    end

    // Final slot length is bit_cnt + 1 including the LSB on the ws-change edge.
    assign slot_good = (bit_cnt >= BIT_LAST);

    always_ff @(posedge clk_12_288 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RX_UNLOCKED;
            ws_prev   <= 1'b0;
            bit_cnt   <= '0;
            run_cnt   <= '0;
            shreg     <= '0;
            hold_l    <= '0;
            l_ok      <= 1'b0;
            audio_l   <= '0;
            audio_r   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (sclk_rise) begin
                case (state)
                    RX_UNLOCKED: begin
                        if (ws != ws_prev) begin
                            state   <= RX_LOCKED;
                            ws_prev <= ws;
                            bit_cnt <= '0;
                            run_cnt <= '0;
                            shreg   <= '0;
                        end
                    end
                    RX_LOCKED: begin
                        if (ws == ws_prev) begin
                            shreg <= word;
                            if (bit_cnt != BIT_SAT) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                            // Word select stuck: drop lock and wait for a fresh transition.
                            if (bit_cnt == BIT_SAT && run_cnt == RUN_LAST) begin
                                state   <= RX_UNLOCKED;
                                l_ok    <= 1'b0;
                                run_cnt <= '0;
                            end else begin
                                run_cnt <= run_cnt + 1'b1;
                            end
                        end else begin
                            if (!slot_good) begin
                                frame_err <= 1'b1;
                                l_ok      <= 1'b0;
                            end else if (ws_prev == CH_LEFT) begin
                                hold_l <= word;
                                l_ok   <= 1'b1;
                            end else begin
                                if (l_ok) begin
                                    audio_l <= hold_l;
                                    audio_r <= word;
                                    valid   <= 1'b1;
                                end
                                l_ok <= 1'b0;
                            end
                            bit_cnt <= '0;
                            run_cnt <= '0;
                            shreg   <= '0;
                            ws_prev <= ws;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: table of frames plus hand-built lock, stall and reset sequences.
// A scoreboard queue holds expected L/R pairs; a negedge monitor pops and compares on each valid.
`timescale 1ns/1ps
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int DW = 16;
    localparam int SS = 2;
    localparam int NV = 15;

    logic          clk_12_288 = 1'b0;
    logic          reset_n    = 1'b0;
    logic          sclk_in    = 1'b0;
    logic          lrclk_in   = 1'b0;
    logic          sd_in      = 1'b0;
    logic [DW-1:0] audio_l;
    logic [DW-1:0] audio_r;
    logic          valid;
    logic          frame_err;

    i2s_rx #(.DATA_BIT(DW), .SYNC_STAGES(SS)) dut (
        .clk_12_288(clk_12_288),
        .reset_n   (reset_n),
        .sclk_in   (sclk_in),
        .lrclk_in  (lrclk_in),
        .sd_in     (sd_in),
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk_12_288 = ~clk_12_288;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    typedef struct {
        logic [DW-1:0] l;
        int            ln;
        logic [DW-1:0] r;
        int            rn;
        bit            exp_valid;
        bit            exp_err;
    } vec_t;

    vec_t   vecs [NV];
    pair_t  exp_q[$];
    int     n_checks  = 0;
    int     n_fail    = 0;
    int     n_valid   = 0;
    int     n_err     = 0;
    int     exp_valid = 0;
    int     exp_err   = 0;
    longint cyc       = 0;
    longint rise_cyc  = 0;

    always @(posedge clk_12_288) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One bit period: data changes with sclk falling, 2 cycles low, 2 cycles high.
    task automatic bit_out(input logic ws, input logic sd);
        sclk_in  = 1'b0;
        lrclk_in = ws;
        sd_in    = sd;
        repeat (2) @(posedge clk_12_288);
        #2;
        sclk_in  = 1'b1;
        rise_cyc = cyc + 1;
        repeat (2) @(posedge clk_12_288);
        #2;
    endtask

    // Philips framing: the slot's last bit goes out with word select already flipped.
    task automatic send_slot_part(input logic ch, input logic [DW-1:0] val,
                                  input int first, input int last, input int n);
        for (int i = first; i <= last; i++) begin
            logic b;
            if (i < DW) b = val[DW-1-i];
            else        b = 1'($urandom_range(1, 0));
            bit_out((i == n - 1) ? ~ch : ch, b);
        end
    endtask

    task automatic send_slot(input logic ch, input logic [DW-1:0] val, input int n);
        send_slot_part(ch, val, 0, n - 1, n);
    endtask

    task automatic expect_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_q.push_back(p);
        exp_valid++;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk_12_288);
        #2;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_valid_count"}, n_valid, exp_valid);
        check({tag, "_err_count"}, n_err, exp_err);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    always @(negedge clk_12_288) begin
        if (valid) begin
            pair_t e;
            n_valid++;
            check("valid_latency", 32'(cyc - rise_cyc), SS);
            check("strobe_overlap", {31'b0, frame_err}, 0);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: audio_l=%h audio_r=%h with no pair pending", audio_l, audio_r);
            end else begin
                e = exp_q.pop_front();
                check("audio_l", audio_l, e.l);
                check("audio_r", audio_r, e.r);
            end
        end
        if (frame_err) begin
            n_err++;
            check("frame_err_latency", 32'(cyc - rise_cyc), SS);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'hDEAD, 32, 16'hBEEF, 32, 1'b0, 1'b0};
        vecs[1] = '{16'hA5C3, 32, 16'h1234, 32, 1'b1, 1'b0};
        vecs[2] = '{16'h0F0F, 12, 16'h7777, 32, 1'b0, 1'b1};
        vecs[3] = '{16'h5A5A, 32, 16'h6B6B, 32, 1'b1, 1'b0};
        vecs[4] = '{16'h8001, 15, 16'h4002, 16, 1'b0, 1'b1};
        vecs[5] = '{16'hC0DE, 16, 16'hF00D, 17, 1'b1, 1'b0};
        vecs[6] = '{16'h1111, 32, 16'h2222,  8, 1'b0, 1'b1};
        for (int n = 0; n < 8; n++) begin
            logic [DW-1:0] v;
            v = DW'(n);
            vecs[7+n] = '{v, 32, ~v, 32, 1'b1, 1'b0};
        end

        repeat (3) @(posedge clk_12_288);
        #2;
        check("reset_audio_l", audio_l, 0);
        check("reset_audio_r", audio_r, 0);
        check("reset_valid", {31'b0, valid}, 0);
        check("reset_frame_err", {31'b0, frame_err}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].exp_valid) expect_pair(vecs[i].l, vecs[i].r);
            if (vecs[i].exp_err) exp_err++;
            send_slot(CH_LEFT, vecs[i].l, vecs[i].ln);
            send_slot(CH_RIGHT, vecs[i].r, vecs[i].rn);
        end
        settle();
        check_counts("table");
        check("hold_audio_l", audio_l, 16'h0007);
        check("hold_audio_r", audio_r, 16'hFFF8);

        // Lock-in: reset released partway through a left slot.
        reset_n = 1'b0;
        send_slot_part(CH_LEFT, 16'hFFFF, 0, 9, 32);
        reset_n = 1'b1;
        send_slot_part(CH_LEFT, 16'hFFFF, 10, 31, 32);
        send_slot(CH_RIGHT, 16'h0001, 32);
        settle();
        check_counts("lockin_partial");
        check("lockin_audio_l_zero", audio_l, 0);
        check("lockin_audio_r_zero", audio_r, 0);
        expect_pair(16'hFFFF, 16'h0001);
        send_slot(CH_LEFT, 16'hFFFF, 32);
        send_slot(CH_RIGHT, 16'h0001, 32);
        settle();
        check_counts("lockin");

        // Stalled word select for 40 bits, then two pairs of which only the second commits.
        for (int i = 0; i < 40; i++) bit_out(1'b0, 1'($urandom_range(1, 0)));
        settle();
        check_counts("stall");
        check("stall_hold_l", audio_l, 16'hFFFF);
        check("stall_hold_r", audio_r, 16'h0001);
        send_slot(CH_LEFT, 16'h1357, 32);
        send_slot(CH_RIGHT, 16'h2468, 32);
        expect_pair(16'h9ABC, 16'hDEF0);
        send_slot(CH_LEFT, 16'h9ABC, 32);
        send_slot(CH_RIGHT, 16'hDEF0, 32);
        settle();
        check_counts("stall_recover");

        // Asynchronous reset in the middle of a right slot.
        send_slot(CH_LEFT, 16'h4321, 32);
        send_slot_part(CH_RIGHT, 16'h8765, 0, 9, 32);
        reset_n = 1'b0;
        #1;
        check("arst_audio_l", audio_l, 0);
        check("arst_audio_r", audio_r, 0);
        check("arst_valid", {31'b0, valid}, 0);
        check("arst_frame_err", {31'b0, frame_err}, 0);
        send_slot_part(CH_RIGHT, 16'h8765, 10, 31, 32);
        send_slot_part(CH_LEFT, 16'h3C3C, 0, 9, 32);
        reset_n = 1'b1;
        send_slot_part(CH_LEFT, 16'h3C3C, 10, 31, 32);
        send_slot(CH_RIGHT, 16'hC3C3, 32);
        settle();
        check_counts("arst_partial");
        check("arst_audio_l_zero", audio_l, 0);
        expect_pair(16'h0BAD, 16'hCAFE);
        send_slot(CH_LEFT, 16'h0BAD, 32);
        send_slot(CH_RIGHT, 16'hCAFE, 32);
        settle();
        check_counts("arst_recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
